axi_r_fifo: RTL and testbench
=============================

AXI_R_FIFO -- requirements
Module: axi_r_fifo

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  WIDTH_ID     4   RID width in bits
  WIDTH_DA     32  RDATA width in bits
  DEPTH_LOG2   2   log2 of entry count; DEPTH = 1<<DEPTH_LOG2
REQ-002 Ports, one per line: name  direction  width  meaning.
  ACLK      in   1                single clock; all logic on its rising edge
  ARESET    in   1                reset, synchronous, active-high
  S_RID     in   WIDTH_ID         upstream (memory-side) read ID
  S_RDATA   in   WIDTH_DA         upstream read data
  S_RRESP   in   2                upstream read response
  S_RLAST   in   1                upstream last beat of burst
  S_RVALID  in   1                upstream beat valid
  S_RREADY  out  1                block can accept a beat
  M_RID     out  WIDTH_ID         downstream (master-side) read ID
  M_RDATA   out  WIDTH_DA         downstream read data
  M_RRESP   out  2                downstream read response
  M_RLAST   out  1                downstream last beat
  M_RVALID  out  1                head entry valid
  M_RREADY  in   1                downstream accepts beat
  LEVEL     out  DEPTH_LOG2+1     entries currently stored
  BURSTS    out  DEPTH_LOG2+1     stored entries with RLAST=1
REQ-003 The block has one clock (ACLK); reset (ARESET) is synchronous and active-high.

Function
REQ-004 The block SHALL store DEPTH entries of {RID, RDATA, RRESP, RLAST} in a circular buffer with write and read pointers that wrap modulo DEPTH.
REQ-005 Push = S_RVALID && S_RREADY; pop = M_RVALID && M_RREADY; each is evaluated on the rising edge of ACLK.
REQ-006 S_RREADY SHALL equal (LEVEL != DEPTH) && !ARESET; it does not depend on M_RREADY, so a full buffer refuses a push even in a cycle with a pop.
REQ-007 M_RVALID SHALL equal (LEVEL != 0); M_RID/M_RDATA/M_RRESP/M_RLAST SHALL be the head entry when LEVEL != 0 and all-zero when LEVEL == 0.
REQ-008 There is no fall-through: a beat pushed into an empty buffer appears on M_R* with M_RVALID=1 in the cycle after the push edge (latency 1 cycle).
REQ-009 While M_RVALID=1 and M_RREADY=0, all M_R* outputs SHALL hold stable.
REQ-010 LEVEL: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
REQ-011 BURSTS: +1 on a push with S_RLAST=1, -1 on a pop with head RLAST=1; when both occur in the same cycle it is unchanged.
REQ-012 Beats SHALL leave in arrival order with payload bit-exact, including RID and RRESP (SLVERR/DECERR are passed through, not interpreted).
REQ-013 Full plus pop: the pop completes, LEVEL becomes DEPTH-1, and S_RREADY rises in the next cycle. Empty plus S_RVALID: the push completes and nothing pops that cycle.
REQ-014 Sustained push and pop at 0 < LEVEL < DEPTH SHALL give 1 beat/cycle throughput.

Reset
REQ-015 While ARESET is high at an edge: pointers, LEVEL and BURSTS go to 0 and every storage entry goes to 0, so M_RVALID=0 and M_R*=0 from the next cycle; S_RREADY=0 in any cycle with ARESET=1.
REQ-016 Reset mid-operation SHALL discard all buffered beats; none SHALL appear on M_R* after reset.

Verification
REQ-017 Reset: ARESET=1 for 3 cycles, then 0 -> LEVEL=0, BURSTS=0, M_RVALID=0, M_RDATA=0, S_RREADY=1 in the first cycle after release.
REQ-018 Fill and drain (DEPTH=4): with M_RREADY=0, push RID=3 data 0x11,0x22,0x33,0x44 (RLAST on 0x44) -> LEVEL=4, BURSTS=1, S_RREADY=0. Then M_RREADY=1 -> 0x11..0x44 out on consecutive cycles, M_RLAST only with 0x44, final LEVEL=0 and BURSTS=0.
REQ-019 Streaming: at LEVEL=2, push and pop every cycle for 10 cycles -> LEVEL stays 2, BURSTS tracks RLAST exactly, output order equals input order.
REQ-020 Full with pop: at LEVEL=4 with S_RVALID=1 and M_RREADY=1 -> S_RREADY=0 that cycle and LEVEL goes 4->3; the push is accepted on the next edge and LEVEL returns to 4.
REQ-021 Mid-op reset: at LEVEL=3, pulse ARESET for one cycle -> M_RVALID=0 and LEVEL=0 from the next cycle, and no pre-reset beat ever emerges.
REQ-022 Random: 1000 beats with random S_RVALID/M_RREADY, RRESP values in {0,2,3} and random RLAST -> scoreboard matches every field, and the bench never sees a push while LEVEL==DEPTH.

Source files
------------

// File: rtl/axi_r_fifo.sv
// AXI read-data channel buffer: a DEPTH-entry circular FIFO for {RID, RDATA, RRESP, RLAST}.
// It has no fall-through path and tracks the occupancy and the number of stored burst ends.
module axi_r_fifo #(
   parameter int WIDTH_ID   = 4,
   parameter int WIDTH_DA   = 32,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic [WIDTH_ID-1:0]   S_RID,
   input  logic [WIDTH_DA-1:0]   S_RDATA,
   input  logic [1:0]            S_RRESP,
   input  logic                  S_RLAST,
   input  logic                  S_RVALID,
   output logic                  S_RREADY,
   output logic [WIDTH_ID-1:0]   M_RID,
   output logic [WIDTH_DA-1:0]   M_RDATA,
   output logic [1:0]            M_RRESP,
   output logic                  M_RLAST,
   output logic                  M_RVALID,
   input  logic                  M_RREADY,
   output logic [DEPTH_LOG2:0]   LEVEL,
   output logic [DEPTH_LOG2:0]   BURSTS
);

   localparam int DEPTH   = 1 << DEPTH_LOG2;
   localparam int WIDTH_E = WIDTH_ID + WIDTH_DA + 3;
   localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   ONE_CNT    = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] ONE_PTR    = DEPTH_LOG2'(1);

   logic [WIDTH_E-1:0]    mem_reg [DEPTH];
   logic [DEPTH-1:0]      wr_en;
   logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
   logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
   logic [DEPTH_LOG2:0]   level_reg, level_next;
   logic [DEPTH_LOG2:0]   bursts_reg, bursts_next;
   logic                  push, pop;
   logic                  last_in, last_out;
   logic [WIDTH_E-1:0]    head;

   // Readiness depends only on occupancy, never on M_RREADY, so a full buffer
   // refuses a beat even in a cycle where it is also being drained.
   assign S_RREADY = (level_reg != FULL_LEVEL) && !ARESET;
   assign M_RVALID = (level_reg != '0);
   assign push     = S_RVALID && S_RREADY;
   assign pop      = M_RVALID && M_RREADY;
   assign last_in  = push && S_RLAST;
   assign last_out = pop && M_RLAST;

   assign head = M_RVALID ? mem_reg[rd_ptr_reg] : '0;
   assign {M_RID, M_RDATA, M_RRESP, M_RLAST} = head;

   assign LEVEL  = level_reg;
   assign BURSTS = bursts_reg;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr_reg == DEPTH_LOG2'(gi));
   end

   // Storage is cleared on reset so that no stale beat can ever be presented again.
   always_ff @(posedge ACLK) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (ARESET) begin
            mem_reg[i] <= '0;
         end else if (wr_en[i]) begin
            mem_reg[i] <= {S_RID, S_RDATA, S_RRESP, S_RLAST};
         end
      end
   end

   always_comb begin
      wr_ptr_next = push ? wr_ptr_reg + ONE_PTR : wr_ptr_reg;
      rd_ptr_next = pop  ? rd_ptr_reg + ONE_PTR : rd_ptr_reg;
      level_next  = level_reg;
      bursts_next = bursts_reg;
      case ({push, pop})
         2'b10:   level_next = level_reg + ONE_CNT;
         2'b01:   level_next = level_reg - ONE_CNT;
         default: level_next = level_reg;
      endcase
      case ({last_in, last_out})
         2'b10:   bursts_next = bursts_reg + ONE_CNT;
         2'b01:   bursts_next = bursts_reg - ONE_CNT;
         default: bursts_next = bursts_reg;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         bursts_reg <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         level_reg  <= level_next;
         bursts_reg <= bursts_next;
      end
   end

endmodule

// File: tb/tb_axi_r_fifo.sv
// Bench for axi_r_fifo: directed fill/drain, streaming, full-with-pop, mid-op reset and random traffic.
// Accepted beats go into a queue; a negedge monitor checks every presented beat and the counters against it.
module tb_axi_r_fifo;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   logic        clk = 1'b0;
   logic        ARESET = 1'b1;
   logic [3:0]  S_RID = '0;
   logic [31:0] S_RDATA = '0;
   logic [1:0]  S_RRESP = '0;
   logic        S_RLAST = 1'b0;
   logic        S_RVALID = 1'b0;
   logic        S_RREADY;
   logic [3:0]  M_RID;
   logic [31:0] M_RDATA;
   logic [1:0]  M_RRESP;
   logic        M_RLAST;
   logic        M_RVALID;
   logic        M_RREADY = 1'b0;
   logic [2:0]  LEVEL;
   logic [2:0]  BURSTS;

   int    vecs = 0;
   int    miss = 0;
   bit    mon_en = 1'b0;
   beat_t exp_q[$];

   always #5 clk = ~clk;

   axi_r_fifo #(.WIDTH_ID(4), .WIDTH_DA(32), .DEPTH_LOG2(2)) dut (
      .ACLK(clk), .ARESET(ARESET),
      .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
      .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
      .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
      .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
      .LEVEL(LEVEL), .BURSTS(BURSTS)
   );

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic beat_t mk(logic [3:0] id, logic [31:0] data, logic [1:0] resp, logic last);
      beat_t b;
      b.id = id; b.data = data; b.resp = resp; b.last = last;
      return b;
   endfunction

   // Monitor: counters and handshakes against the queue model, and payload against the queue head.
   always @(negedge clk) begin
      int n;
      int nb;
      if (mon_en) begin
         n  = exp_q.size();
         nb = 0;
         foreach (exp_q[k]) if (exp_q[k].last) nb++;
         chk("level_model", LEVEL, n);
         chk("bursts_model", BURSTS, nb);
         chk("m_rvalid_model", M_RVALID, n != 0);
         chk("s_rready_model", S_RREADY, (n != 4) && !ARESET);
         chk("push_at_full", S_RVALID && S_RREADY && (LEVEL == 3'd4), 0);
         if (M_RVALID) begin
            if (n == 0) begin
               chk("unexpected_beat", M_RDATA, 0);
            end else begin
               chk("m_rid", M_RID, exp_q[0].id);
               chk("m_rdata", M_RDATA, exp_q[0].data);
               chk("m_rresp", M_RRESP, exp_q[0].resp);
               chk("m_rlast", M_RLAST, exp_q[0].last);
               if (M_RREADY && !ARESET) void'(exp_q.pop_front());
            end
         end else begin
            chk("idle_payload", {M_RID, M_RDATA, M_RRESP, M_RLAST}, 0);
         end
      end
   end

   // One bus cycle: drive after the edge, record acceptance just after the monitor's negedge.
   task automatic cyc(input logic v, input beat_t b, input logic rr, output logic acc);
      @(posedge clk);
      #1;
      S_RVALID = v;
      {S_RID, S_RDATA, S_RRESP, S_RLAST} = v ? b : '0;
      M_RREADY = rr;
      @(negedge clk);
      #1;
      acc = S_RVALID && S_RREADY;
      if (acc) exp_q.push_back(b);
   endtask

   initial begin
      logic        acc;
      beat_t       bx;
      logic [31:0] fill_data [4];
      logic [1:0]  resp_tab [3];
      int          done;
      int          guard;
      logic        have;

      fill_data[0] = 32'h11; fill_data[1] = 32'h22; fill_data[2] = 32'h33; fill_data[3] = 32'h44;
      resp_tab[0] = 2'd0; resp_tab[1] = 2'd2; resp_tab[2] = 2'd3;

      // Reset held for three edges, then released
      repeat (3) @(posedge clk);
      #1;
      ARESET = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_level", LEVEL, 0);
      chk("rst_bursts", BURSTS, 0);
      chk("rst_m_rvalid", M_RVALID, 0);
      chk("rst_m_rdata", M_RDATA, 0);
      chk("rst_s_rready", S_RREADY, 1);

      // Fill with the consumer stalled, then drain
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, mk(4'd3, fill_data[i], 2'd0, i == 3), 1'b0, acc);
         chk("fill_accept", acc, 1);
      end
      cyc(1'b0, '0, 1'b0, acc);
      chk("full_level", LEVEL, 4);
      chk("full_bursts", BURSTS, 1);
      chk("full_s_rready", S_RREADY, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, '0, 1'b1, acc);
         chk("drain_valid", M_RVALID, 1);
         chk("drain_data", M_RDATA, fill_data[i]);
         chk("drain_id", M_RID, 3);
         chk("drain_last", M_RLAST, i == 3);
      end
      cyc(1'b0, '0, 1'b0, acc);
      chk("drained_level", LEVEL, 0);
      chk("drained_bursts", BURSTS, 0);

      // Streaming at LEVEL=2
      cyc(1'b1, mk(4'd1, 32'h100, 2'd0, 1'b0), 1'b0, acc);
      cyc(1'b1, mk(4'd2, 32'h101, 2'd2, 1'b1), 1'b0, acc);
      for (int k = 0; k < 10; k++) begin
         cyc(1'b1, mk(4'(k), 32'h200 + 32'(k), 2'(k % 4), (k % 3) == 2), 1'b1, acc);
         chk("stream_accept", acc, 1);
         chk("stream_level", LEVEL, 2);
      end
      cyc(1'b0, '0, 1'b0, acc);
      chk("stream_end_level", LEVEL, 2);

      // Full with simultaneous pop: push refused, accepted on the following edge
      cyc(1'b1, mk(4'd5, 32'h300, 2'd0, 1'b0), 1'b0, acc);
      cyc(1'b1, mk(4'd6, 32'h301, 2'd3, 1'b1), 1'b0, acc);
      cyc(1'b0, '0, 1'b0, acc);
      chk("fp_full_level", LEVEL, 4);
      bx = mk(4'd7, 32'h302, 2'd2, 1'b1);
      cyc(1'b1, bx, 1'b1, acc);
      chk("fp_refused", acc, 0);
      chk("fp_level_before", LEVEL, 4);
      cyc(1'b1, bx, 1'b0, acc);
      chk("fp_accepted", acc, 1);
      chk("fp_level_after_pop", LEVEL, 3);
      cyc(1'b0, '0, 1'b0, acc);
      chk("fp_level_refilled", LEVEL, 4);
      repeat (4) cyc(1'b0, '0, 1'b1, acc);
      cyc(1'b0, '0, 1'b0, acc);
      chk("fp_drained", LEVEL, 0);

      // Mid-operation reset discards everything
      for (int i = 0; i < 3; i++) cyc(1'b1, mk(4'd9, 32'hA0 + 32'(i), 2'd0, i == 1), 1'b0, acc);
      cyc(1'b0, '0, 1'b0, acc);
      chk("mid_level", LEVEL, 3);
      @(posedge clk);
      #1;
      ARESET = 1'b1;
      S_RVALID = 1'b0;
      M_RREADY = 1'b1;
      @(negedge clk);
      #1;
      chk("mid_rst_s_rready", S_RREADY, 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      ARESET = 1'b0;
      @(negedge clk);
      #1;
      chk("mid_rst_m_rvalid", M_RVALID, 0);
      chk("mid_rst_level", LEVEL, 0);
      chk("mid_rst_bursts", BURSTS, 0);
      repeat (5) begin
         cyc(1'b0, '0, 1'b1, acc);
         chk("mid_rst_quiet", M_RVALID, 0);
      end

      // Random traffic: 1000 beats
      done  = 0;
      guard = 0;
      have  = 1'b0;
      while (done < 1000 && guard < 20000) begin
         if (!have) begin
            bx = mk(4'($urandom), $urandom, resp_tab[$urandom_range(0, 2)], 1'($urandom_range(0, 1)));
            have = 1'b1;
         end
         cyc($urandom_range(0, 3) != 0, bx, 1'($urandom_range(0, 1)), acc);
         if (acc) begin
            done++;
            have = 1'b0;
         end
         guard++;
      end
      chk("random_beats", done, 1000);
      guard = 0;
      while (LEVEL != 0 && guard < 100) begin
         cyc(1'b0, '0, 1'b1, acc);
         guard++;
      end
      cyc(1'b0, '0, 1'b0, acc);
      chk("random_drained", LEVEL, 0);
      chk("random_bursts", BURSTS, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
